// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//
// Decodes PS/2 scan-code set 2 bytes from the byte receiver and keeps track of
// the single key currently held down. It sits in front of the seven-segment
// display driver. It parses make, break and E0-extended sequences, keeps a
// short history of recent new presses and counts presses. A prefix byte that
// is never followed up is abandoned after TIMEOUT cycles.
//
// Parameters:
//   HIST_DEPTH   number of recent make codes kept in hist (>=1)
//   CNT_W        width of press_cnt
//   COUNT_REPEAT 1 = typematic repeats of the held key also count as presses
//   CNT_SAT      1 = press_cnt sticks at all-ones, 0 = wraps to zero
//   TIMEOUT      cycles allowed between a prefix byte and the next byte (>=2)
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   ps2_data      received byte, qualified by ps2_valid
//   ps2_valid     one-cycle strobe per received byte
//   key_down      a key is currently held
//   key_code      code of the held (or last held) key
//   key_ext       held (or last held) key was E0-prefixed
//   segs_enable   display enable, same as key_down
//   press_cnt     number of counted presses
//   hist          recent make codes, newest in bits [7:0]
//   evt_make      one-cycle pulse on a counted make
//   evt_break     one-cycle pulse when the held key is released

module ps2_key_tracker #(
    parameter int HIST_DEPTH   = 4,
    parameter int CNT_W        = 8,
    parameter int COUNT_REPEAT = 0,
    parameter int CNT_SAT      = 0,
    parameter int TIMEOUT      = 2000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              ps2_data,
    input  logic                    ps2_valid,
    output logic                    key_down,
    output logic [7:0]              key_code,
    output logic                    key_ext,
    output logic                    segs_enable,
    output logic [CNT_W-1:0]        press_cnt,
    output logic [8*HIST_DEPTH-1:0] hist,
    output logic                    evt_make,
    output logic                    evt_break
);

    localparam int HW = 8 * HIST_DEPTH;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRE_E0 = 2'd1;
    localparam logic [1:0] ST_PRE_F0 = 2'd2;

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;

    logic [1:0]       state_q,     state_d;
    logic             ext_q,       ext_d;
    logic [TW-1:0]    to_cnt_q,    to_cnt_d;
    logic             key_down_q,  key_down_d;
    logic [7:0]       key_code_q,  key_code_d;
    logic             key_ext_q,   key_ext_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [HW-1:0]    hist_q,      hist_d;
    logic             evt_make_q,  evt_make_d;
    logic             evt_break_q, evt_break_d;

    logic             do_make;
    logic             do_break;
    logic             seq_ext;
    logic             ignored_byte;
    logic             held_match;
    logic [CNT_W-1:0] cnt_next;

    // Acknowledge, self-test and overrun bytes from the keyboard never
    // describe a key, so they are dropped when no sequence is in progress.
    always_comb begin
        ignored_byte = 1'b0;
        case (ps2_data)
            8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ignored_byte = 1'b1;
            default:                                         ignored_byte = 1'b0;
        endcase
    end

    // Sequence parser. The timeout counter only runs while waiting after a
    // prefix; an arriving byte always wins over an expiring timeout.
    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        to_cnt_d = to_cnt_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        seq_ext  = ext_q;

        if (ps2_valid) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (ps2_data == B_E0) begin
                        state_d = ST_PRE_E0;
                        ext_d   = 1'b1;
                    end else if (ps2_data == B_F0) begin
                        state_d = ST_PRE_F0;
                        ext_d   = 1'b0;
                    end else if (!ignored_byte) begin
                        do_make = 1'b1;
                        seq_ext = 1'b0;
                    end
                end
                ST_PRE_E0: begin
                    if (ps2_data == B_F0) begin
                        state_d = ST_PRE_F0;
                    end else if (ps2_data == B_E0) begin
                        ext_d = 1'b1;
                    end else begin
                        do_make = 1'b1;
                        seq_ext = 1'b1;
                        state_d = ST_IDLE;
                        ext_d   = 1'b0;
                    end
                end
                ST_PRE_F0: begin
                    if (ps2_data == B_E0) begin
                        // E0 after F0 is out of order; restart as an extended sequence.
                        state_d = ST_PRE_E0;
                        ext_d   = 1'b1;
                    end else if (ps2_data != B_F0) begin
                        do_break = 1'b1;
                        seq_ext  = ext_q;
                        state_d  = ST_IDLE;
                        ext_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ext_d   = 1'b0;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (to_cnt_q == TO_LAST) begin
                state_d  = ST_IDLE;
                ext_d    = 1'b0;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
    end

    // Key tracking. Only one key is tracked; a new make replaces whatever was
    // held. A repeat of the held key never touches hist.
    always_comb begin
        key_down_d  = key_down_q;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        press_cnt_d = press_cnt_q;
        hist_d      = hist_q;
        evt_make_d  = 1'b0;
        evt_break_d = 1'b0;

        held_match = key_down_q && (ps2_data == key_code_q) && (seq_ext == key_ext_q);

        if ((press_cnt_q == '1) && (CNT_SAT != 0)) begin
            cnt_next = press_cnt_q;
        end else begin
            cnt_next = press_cnt_q + CNT_W'(1);
        end

        if (do_make) begin
            if (held_match) begin
                if (COUNT_REPEAT != 0) begin
                    press_cnt_d = cnt_next;
                    evt_make_d  = 1'b1;
                end
            end else begin
                key_down_d  = 1'b1;
                key_code_d  = ps2_data;
                key_ext_d   = seq_ext;
                hist_d      = (hist_q << 8) | HW'(ps2_data);
                press_cnt_d = cnt_next;
                evt_make_d  = 1'b1;
            end
        end else if (do_break && held_match) begin
            key_down_d  = 1'b0;
            evt_break_d = 1'b1;
        end
    end

    // All state registers; reset clears everything including a partial prefix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ext_q       <= 1'b0;
            to_cnt_q    <= '0;
            key_down_q  <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            press_cnt_q <= '0;
            hist_q      <= '0;
            evt_make_q  <= 1'b0;
            evt_break_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_q       <= ext_d;
            to_cnt_q    <= to_cnt_d;
            key_down_q  <= key_down_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            press_cnt_q <= press_cnt_d;
            hist_q      <= hist_d;
            evt_make_q  <= evt_make_d;
            evt_break_q <= evt_break_d;
        end
    end

    assign key_down    = key_down_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign segs_enable = key_down_q;
    assign press_cnt   = press_cnt_q;
    assign hist        = hist_q;
    assign evt_make    = evt_make_q;
    assign evt_break   = evt_break_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker
//
// Drives three ps2_key_tracker instances with the same byte stream:
//   dut_a: 8-bit counter, repeats not counted
//   dut_b: 2-bit saturating counter, repeats counted
//   dut_c: 2-bit wrapping counter, repeats not counted
// All use HIST_DEPTH=4 and TIMEOUT=16. Expected events are queued per
// instance when stimulus is issued; a monitor pops and compares on every
// evt_make/evt_break pulse.

module tb_ps2_key_tracker;

    logic        clk;
    logic        rst;
    logic [7:0]  ps2_data;
    logic        ps2_valid;

    logic        a_down, b_down, c_down;
    logic [7:0]  a_code, b_code, c_code;
    logic        a_ext, b_ext, c_ext;
    logic        a_segs, b_segs, c_segs;
    logic [7:0]  a_cnt;
    logic [1:0]  b_cnt, c_cnt;
    logic [31:0] a_hist, b_hist, c_hist;
    logic        a_make, b_make, c_make;
    logic        a_brk, b_brk, c_brk;

    int pass_count  = 0;
    int total_count = 0;

    logic [50:0] q_a[$];
    logic [50:0] q_b[$];
    logic [50:0] q_c[$];

    ps2_key_tracker #(.HIST_DEPTH(4), .CNT_W(8), .COUNT_REPEAT(0), .CNT_SAT(0), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
        .key_down(a_down), .key_code(a_code), .key_ext(a_ext), .segs_enable(a_segs),
        .press_cnt(a_cnt), .hist(a_hist), .evt_make(a_make), .evt_break(a_brk)
    );

    ps2_key_tracker #(.HIST_DEPTH(4), .CNT_W(2), .COUNT_REPEAT(1), .CNT_SAT(1), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
        .key_down(b_down), .key_code(b_code), .key_ext(b_ext), .segs_enable(b_segs),
        .press_cnt(b_cnt), .hist(b_hist), .evt_make(b_make), .evt_break(b_brk)
    );

    ps2_key_tracker #(.HIST_DEPTH(4), .CNT_W(2), .COUNT_REPEAT(0), .CNT_SAT(0), .TIMEOUT(16)) dut_c (
        .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
        .key_down(c_down), .key_code(c_code), .key_ext(c_ext), .segs_enable(c_segs),
        .press_cnt(c_cnt), .hist(c_hist), .evt_make(c_make), .evt_break(c_brk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [50:0] packEvt(input logic mk, input logic [7:0] code,
                                            input logic ext, input logic down,
                                            input logic [7:0] cnt, input logic [31:0] h);
        return {mk, code, ext, down, cnt, h};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_count++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end else begin
            pass_count++;
        end
    endtask

    task automatic expectEvt(input int d, input logic mk, input logic [7:0] code,
                             input logic ext, input logic down, input logic [7:0] cnt,
                             input logic [31:0] h);
        case (d)
            0:       q_a.push_back(packEvt(mk, code, ext, down, cnt, h));
            1:       q_b.push_back(packEvt(mk, code, ext, down, cnt, h));
            default: q_c.push_back(packEvt(mk, code, ext, down, cnt, h));
        endcase
    endtask

    task automatic expectAll(input logic mk, input logic [7:0] code, input logic ext,
                             input logic [7:0] ca, input logic [7:0] cb, input logic [7:0] cc,
                             input logic [31:0] h);
        expectEvt(0, mk, code, ext, mk, ca, h);
        expectEvt(1, mk, code, ext, mk, cb, h);
        expectEvt(2, mk, code, ext, mk, cc, h);
    endtask

    task automatic checkEvent(input int d, input logic [50:0] act);
        logic [50:0] exp;
        int          depth;
        string       name;
        case (d)
            0:       begin depth = q_a.size(); name = "evt_a"; end
            1:       begin depth = q_b.size(); name = "evt_b"; end
            default: begin depth = q_c.size(); name = "evt_c"; end
        endcase
        if (depth == 0) begin
            total_count++;
            $display("[TB] FAIL %s unexpected: got %h, expected no event at %0t", name, act, $time);
        end else begin
            case (d)
                0:       exp = q_a.pop_front();
                1:       exp = q_b.pop_front();
                default: exp = q_c.pop_front();
            endcase
            checkOutput(name, 64'(act), 64'(exp));
        end
    endtask

    // Event monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_make || a_brk) begin
                checkOutput("excl_a", 64'(a_make & a_brk), 64'd0);
                checkEvent(0, packEvt(a_make, a_code, a_ext, a_down, a_cnt, a_hist));
            end
            if (b_make || b_brk) begin
                checkOutput("excl_b", 64'(b_make & b_brk), 64'd0);
                checkEvent(1, packEvt(b_make, b_code, b_ext, b_down, {6'd0, b_cnt}, b_hist));
            end
            if (c_make || c_brk) begin
                checkOutput("excl_c", 64'(c_make & c_brk), 64'd0);
                checkEvent(2, packEvt(c_make, c_code, c_ext, c_down, {6'd0, c_cnt}, c_hist));
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        ps2_data  = b;
        ps2_valid = 1'b1;
        @(posedge clk);
        #1;
        ps2_valid = 1'b0;
        ps2_data  = 8'h00;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_down"},  64'({a_down, b_down, c_down}), 64'd0);
        checkOutput({tag, "_code"},  64'({a_code, b_code, c_code}), 64'd0);
        checkOutput({tag, "_ext"},   64'({a_ext, b_ext, c_ext}), 64'd0);
        checkOutput({tag, "_segs"},  64'({a_segs, b_segs, c_segs}), 64'd0);
        checkOutput({tag, "_cnt"},   64'({a_cnt, b_cnt, c_cnt}), 64'd0);
        checkOutput({tag, "_hist"},  64'(a_hist | b_hist | c_hist), 64'd0);
        checkOutput({tag, "_evt"},   64'({a_make, b_make, c_make, a_brk, b_brk, c_brk}), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        ps2_data  = 8'h00;
        ps2_valid = 1'b0;
        idleCycles(2);
        checkAllZero("reset");
        rst = 1'b0;
        idleCycles(2);

        // Plain make then break.
        expectAll(1'b1, 8'h1C, 1'b0, 8'd1, 8'd1, 8'd1, 32'h0000001C);
        applyStimulus(8'h1C);
        checkOutput("segs_follow", 64'({a_segs, a_down}), 64'b11);
        expectAll(1'b0, 8'h1C, 1'b0, 8'd1, 8'd1, 8'd1, 32'h0000001C);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);

        // Extended make; a plain break of the same code must not release it.
        expectAll(1'b1, 8'h75, 1'b1, 8'd2, 8'd2, 8'd2, 32'h00001C75);
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        checkOutput("ext_hold", 64'({a_down, a_code, a_ext}), 64'({1'b1, 8'h75, 1'b1}));
        expectAll(1'b0, 8'h75, 1'b1, 8'd2, 8'd2, 8'd2, 32'h00001C75);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);

        // Typematic repeats: only dut_b counts them, and it saturates at 3.
        expectAll(1'b1, 8'h1C, 1'b0, 8'd3, 8'd3, 8'd3, 32'h001C751C);
        expectEvt(1, 1'b1, 8'h1C, 1'b0, 1'b1, 8'd3, 32'h001C751C);
        expectEvt(1, 1'b1, 8'h1C, 1'b0, 1'b1, 8'd3, 32'h001C751C);
        applyStimulus(8'h1C);
        applyStimulus(8'h1C);
        applyStimulus(8'h1C);
        checkOutput("rep_cnt", 64'({a_cnt, b_cnt, c_cnt}), 64'({8'd3, 2'd3, 2'd3}));
        checkOutput("rep_hist", 64'(a_hist), 64'h001C751C);
        expectAll(1'b0, 8'h1C, 1'b0, 8'd3, 8'd3, 8'd3, 32'h001C751C);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);

        // History shifting; dut_c wraps 3 -> 0, dut_b stays at 3.
        expectAll(1'b1, 8'h32, 1'b0, 8'd4, 8'd3, 8'd0, 32'h1C751C32);
        expectAll(1'b0, 8'h32, 1'b0, 8'd4, 8'd3, 8'd0, 32'h1C751C32);
        applyStimulus(8'h32); applyStimulus(8'hF0); applyStimulus(8'h32);
        expectAll(1'b1, 8'h21, 1'b0, 8'd5, 8'd3, 8'd1, 32'h751C3221);
        expectAll(1'b0, 8'h21, 1'b0, 8'd5, 8'd3, 8'd1, 32'h751C3221);
        applyStimulus(8'h21); applyStimulus(8'hF0); applyStimulus(8'h21);
        expectAll(1'b1, 8'h23, 1'b0, 8'd6, 8'd3, 8'd2, 32'h1C322123);
        expectAll(1'b0, 8'h23, 1'b0, 8'd6, 8'd3, 8'd2, 32'h1C322123);
        applyStimulus(8'h23); applyStimulus(8'hF0); applyStimulus(8'h23);
        expectAll(1'b1, 8'h24, 1'b0, 8'd7, 8'd3, 8'd3, 32'h32212324);
        expectAll(1'b0, 8'h24, 1'b0, 8'd7, 8'd3, 8'd3, 32'h32212324);
        applyStimulus(8'h24); applyStimulus(8'hF0); applyStimulus(8'h24);
        checkOutput("hist_shift", 64'(a_hist), 64'h32212324);

        // E0 then the next byte on the last allowed cycle: byte wins.
        expectAll(1'b1, 8'h75, 1'b1, 8'd8, 8'd3, 8'd0, 32'h21232475);
        applyStimulus(8'hE0);
        idleCycles(15);
        applyStimulus(8'h75);
        expectAll(1'b0, 8'h75, 1'b1, 8'd8, 8'd3, 8'd0, 32'h21232475);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);

        // E0 abandoned after timeout: following byte is a plain make.
        expectAll(1'b1, 8'h1C, 1'b0, 8'd9, 8'd3, 8'd1, 32'h2324751C);
        applyStimulus(8'hE0);
        idleCycles(16);
        applyStimulus(8'h1C);
        expectAll(1'b0, 8'h1C, 1'b0, 8'd9, 8'd3, 8'd1, 32'h2324751C);
        applyStimulus(8'hF0); applyStimulus(8'h1C);

        // F0 abandoned after timeout: following byte is a make, not a break.
        expectAll(1'b1, 8'h1C, 1'b0, 8'd10, 8'd3, 8'd2, 32'h24751C1C);
        applyStimulus(8'hF0);
        idleCycles(16);
        applyStimulus(8'h1C);
        expectAll(1'b0, 8'h1C, 1'b0, 8'd10, 8'd3, 8'd2, 32'h24751C1C);
        applyStimulus(8'hF0); applyStimulus(8'h1C);

        // Reset between F0 and its code: everything clears, code becomes a make.
        applyStimulus(8'hF0);
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        idleCycles(1);
        rst = 1'b0;
        idleCycles(1);
        expectAll(1'b1, 8'h1C, 1'b0, 8'd1, 8'd1, 8'd1, 32'h0000001C);
        applyStimulus(8'h1C);

        // Ignored bytes and a non-matching break leave the held key alone.
        applyStimulus(8'hFA);
        applyStimulus(8'hAA);
        applyStimulus(8'hF0);
        applyStimulus(8'h32);
        checkOutput("ignored", 64'({a_down, a_code, a_cnt}), 64'({1'b1, 8'h1C, 8'd1}));

        // F0 E0 is treated as a fresh extended sequence; new key replaces 1C.
        expectAll(1'b1, 8'h75, 1'b1, 8'd2, 8'd2, 8'd2, 32'h00001C75);
        applyStimulus(8'hF0);
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        expectAll(1'b0, 8'h75, 1'b1, 8'd2, 8'd2, 8'd2, 32'h00001C75);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);

        // Break of a key no longer held changes nothing.
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        checkOutput("stale_brk", 64'({a_down, a_code, a_ext}), 64'({1'b0, 8'h75, 1'b1}));

        idleCycles(4);
        checkOutput("queues_drained", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised PS/2 set-2 scan-code decoder sitting between the PS/2 byte receiver and the seven-segment display driver. It parses make, break and E0-extended sequences and tracks the currently held key. It also keeps a history of the last HIST_DEPTH distinct key presses, counts presses (typematic repeats optional), and aborts stale prefix sequences on a timeout.

Parameters:
HIST_DEPTH, 4, number of recent make codes kept (>=1)
CNT_W, 8, width of press counter
COUNT_REPEAT, 0, 1 = typematic repeats of held key increment press_cnt
CNT_SAT, 0, 1 = press_cnt saturates at all-ones; 0 = wraps to 0
TIMEOUT, 2000000, cycles allowed between prefix byte and next byte before abort (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
ps2_data  input  8  received byte, valid when ps2_valid=1
ps2_valid  input  1  one-cycle pulse per received byte
key_down  output  1  1 while a key is held
key_code  output  8  code of held/last-held key
key_ext  output  1  held/last-held key was E0-prefixed
segs_enable  output  1  display enable, equals key_down
press_cnt  output  CNT_W  number of counted presses
hist  output  8*HIST_DEPTH  last make codes, newest in bits [7:0]
evt_make  output  1  one-cycle pulse on counted make
evt_break  output  1  one-cycle pulse on release of held key

Behaviour:
- Reset is asynchronous, active-high (rst=1 asserts immediately, independent of clk). All outputs go to 0, hist to all 0, the FSM goes to IDLE, and the ext flag and timeout counter clear. Reset mid-sequence discards any partial prefix.
- Bytes are consumed only on clk edges with ps2_valid=1. All outputs are registered and update on the same edge that consumes the final byte of a sequence, so they are visible the following cycle.
- FSM states: IDLE, PRE_E0, PRE_F0. A registered ext flag records whether E0 was seen in the current sequence.
- IDLE:
  - byte E0 -> PRE_E0, ext=1.
  - byte F0 -> PRE_F0, ext=0.
  - byte E1, FA, AA, EE, FE, 00 or FF -> ignored, stay in IDLE.
  - any other byte -> make(code, ext=0).
- PRE_E0:
  - byte F0 -> PRE_F0, ext stays 1.
  - byte E0 -> stay, ext=1.
  - any other byte -> make(code, ext=1), return to IDLE.
- PRE_F0:
  - byte F0 -> stay.
  - byte E0 -> protocol error: go to PRE_E0, ext=1.
  - any other byte -> break(code, ext), return to IDLE.
- make(c,e):
  - If key_down=1 and {c,e}={key_code,key_ext}, this is a repeat. hist is unchanged. press_cnt and evt_make fire only if COUNT_REPEAT=1.
  - Otherwise it is a new press: key_down=1, key_code=c, key_ext=e, hist shifts (new code in [7:0], oldest dropped), press_cnt increments, evt_make=1.
  - A new key while another is held replaces it (single-slot tracking).
- break(c,e):
  - If key_down=1 and {c,e} matches the held key: key_down=0, evt_break=1. key_code and key_ext hold their last value.
  - A non-matching break is ignored.
- press_cnt at all-ones: CNT_SAT=1 holds the value; CNT_SAT=0 wraps to 0.
- Timeout:
  - The counter runs only in PRE_E0 and PRE_F0 and resets on every consumed byte.
  - When it reaches TIMEOUT-1 with no ps2_valid that cycle, the FSM returns to IDLE, ext=0, and no event is produced.
  - If ps2_valid arrives in the same cycle as the timeout, the byte wins and is processed normally.
- evt_make and evt_break are never both 1 in the same cycle; each is high for exactly one cycle.
- hist is written only on new presses, never on repeats or breaks.

Test Plan:
- Reset, then bytes 1C, F0, 1C -> key_down=1, key_code=1C after the 1st byte; press_cnt=1, hist[7:0]=1C, evt_make pulses once; after the 3rd byte key_down=0 and evt_break pulses once.
- Bytes E0 75, E0 F0 75 -> key_ext=1, key_code=75, key_down 1 then 0; a plain F0 75 alone does not release an E0 75 hold.
- Bytes 1C 1C 1C (repeat), COUNT_REPEAT=0 -> press_cnt=1, one evt_make; with COUNT_REPEAT=1 -> press_cnt=3, hist still 1C,00,00,00.
- Presses 1C, 32, 21, 23, 24 with breaks between, HIST_DEPTH=4 -> hist = {1C,32,21,23... shifted} with newest 24 in [7:0], 32 in [31:24]; 1C dropped.
- CNT_W=2: 5 distinct presses -> CNT_SAT=0 gives press_cnt=1; CNT_SAT=1 gives press_cnt=3.
- TIMEOUT=16: E0, idle 16 cycles, then 1C -> make with key_ext=0. Separately, rst pulsed between F0 and 1C -> 1C is treated as a make; all outputs are 0 during reset.
